// File: rtl/adc_pipe_pkg.sv
// Shared types and constants for the pipelined-ADC control sequencer.
// The phase helpers define where the non-overlapping sample/amplify windows sit in a period.
package adc_pipe_pkg;

    localparam int CODE_W     = 3;
    localparam int PERIOD_DEF = 8;
    localparam int LAT_DEF    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } seq_state_t;

    // cnt 0 and cnt period/2 are the non-overlap gaps between the two phases
    function automatic logic phi1_active(input int cnt, input int period);
        return (cnt >= 1) && (cnt < period / 2);
    endfunction

    function automatic logic phi2_active(input int cnt, input int period);
        return (cnt >= period / 2 + 1) && (cnt < period);
    endfunction

endpackage

// File: rtl/adc_pipe_seq_fifo.sv
// Two-entry show-ahead FIFO for encoder codes; a pop frees its slot for a push in the same cycle.
module adc_pipe_seq_fifo
    import adc_pipe_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [CODE_W-1:0] data_i,
    output logic [CODE_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [CODE_W-1:0] mem_q [2];
    logic              rd_q;
    logic              wr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop_i && (cnt_q != 2'd0);
    assign push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_ok) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/adc_pipe_sequencer.sv
// Sequencer for the 3-stage 1.5-bit pipelined ADC: phase generation, fill-latency skip,
// burst counting and valid/ready delivery of aligned codes.
//   state  | meaning
//   IDLE   | phases off, waiting for start
//   WARMUP | phases running, discarding LAT conversions of pipeline fill
//   RUN    | phases running, one code captured per period at cnt 0
//   DRAIN  | phases off, waiting for consumer to empty the FIFO
module adc_pipe_sequencer
    import adc_pipe_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int LAT     = LAT_DEF,
    parameter int BURST_W = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic [CODE_W-1:0]  code_i,
    input  logic               ready_i,
    output logic               phi1_o,
    output logic               phi2_o,
    output logic               enc_en_o,
    output logic [CODE_W-1:0]  code_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overflow_o
);

    if (PERIOD < 4 || (PERIOD % 2) != 0) begin : g_bad_period
        $error("adc_pipe_sequencer: PERIOD must be even and at least 4");
    end
    if (LAT < 1) begin : g_bad_lat
        $error("adc_pipe_sequencer: LAT must be at least 1");
    end

    localparam int CNT_W  = $clog2(PERIOD);
    localparam int TICK_W = (LAT > 1) ? $clog2(LAT) : 1;

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [BURST_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               stop_req_q, stop_req_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               running;
    logic               last;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    assign running = (state_q == ST_WARMUP) || (state_q == ST_RUN);
    assign last    = (cnt_q == CNT_W'(PERIOD - 1));
    assign pop     = valid_o && ready_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tick_d     = tick_q;
        cap_cnt_d  = cap_cnt_q;
        burst_d    = burst_q;
        stop_req_d = stop_req_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        push       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i && !stop_i) begin
                    state_d    = ST_WARMUP;
                    burst_d    = burst_len_i;
                    tick_d     = '0;
                    cap_cnt_d  = '0;
                    ovf_d      = 1'b0;
                    stop_req_d = 1'b0;
                end
            end
            ST_WARMUP: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (stop_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (last) begin
                    if (tick_q == TICK_W'(LAT - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (stop_i) begin
                    stop_req_d = 1'b1;
                end
                // code_i is stable from the encoder one cycle after its capture enable
                if (cnt_q == '0) begin
                    push      = 1'b1;
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (fifo_full && !pop) begin
                        ovf_d = 1'b1;
                    end
                    if (((burst_q != '0) && (cap_cnt_d == burst_q)) || stop_req_q || stop_i) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = '0;
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tick_q     <= '0;
            cap_cnt_q  <= '0;
            burst_q    <= '0;
            stop_req_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            cap_cnt_q  <= cap_cnt_d;
            burst_q    <= burst_d;
            stop_req_q <= stop_req_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    adc_pipe_seq_fifo u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (code_i),
        .data_o  (code_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign phi1_o     = running && phi1_active(32'(cnt_q), PERIOD);
    assign phi2_o     = running && phi2_active(32'(cnt_q), PERIOD);
    assign enc_en_o   = running && last;
    assign valid_o    = !fifo_empty;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule
